seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one
//  BCD-to-segment decoder (inputs b3..b0, outputs a..g). Cycles through the digits: drives the

---
 rtl/seven_seg_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment digits
// sharing one BCD decoder. Each digit slot is an ON phase followed by an all-off BLANK gap.
// New display words arrive over a valid/ready port and are applied only at frame boundaries.
// Optional build macro: SEG_LZ_BLANK_EN enables leading-zero suppression.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   dig_an_n,
    output logic                    frame_start
);

    localparam int unsigned IdxW     = $clog2(NUM_DIGITS);
    localparam int unsigned CntW     = $clog2(PRESCALE);
    localparam int unsigned OnCycles = PRESCALE - BLANK_CYCLES;

    localparam logic [CntW-1:0] OnLast   = CntW'(OnCycles - 1);
    localparam logic [CntW-1:0] SlotLast = CntW'(PRESCALE - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StOn, StBlank} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic                    load_ready_q, load_ready_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fs_q, fs_d;

    logic                    enter_frame;
    logic [3:0]              nib;
    logic                    lz_ok;

    // Scan sequencing: slot counter runs 0..PRESCALE-1, ON first then BLANK.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StOn;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                StOn: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OnLast) begin
                        state_d = StBlank;
                    end
                end
                StBlank: begin
                    if (cnt_q == SlotLast) begin
                        state_d = StOn;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Frame boundary: the edge that moves into ON for digit 0 from IDLE or BLANK.
    assign enter_frame = (state_d == StOn) && (idx_d == '0) && (state_q != StOn);

    // Load port: capture into pending, copy to shadow at a frame boundary or while idle,
    // and reopen the port one cycle after the copy.
    always_comb begin
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        shadow_d     = shadow_q;
        load_ready_d = load_ready_q;
        if (load_valid && load_ready_q) begin
            pend_d       = load_data;
            pend_full_d  = 1'b1;
            load_ready_d = 1'b0;
        end else if (pend_full_q && (state_q == StIdle || enter_frame)) begin
            shadow_d    = pend_q;
            pend_full_d = 1'b0;
        end else if (!load_ready_q && !pend_full_q) begin
            load_ready_d = 1'b1;
        end
    end

    // Nibble for the digit being entered; decided from shadow_d so a fresh copy shows at once.
    assign nib = shadow_d[{idx_d, 2'b00} +: 4];

`ifdef SEG_LZ_BLANK_EN
    logic [IdxW-1:0] msd;

    // Highest nonzero digit; everything above it is dark, digit 0 always lit.
    always_comb begin
        msd = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (shadow_d[4*k +: 4] != 4'h0) begin
                msd = IdxW'(k);
            end
        end
        lz_ok = (idx_d <= msd);
    end
`else
    assign lz_ok = 1'b1;
`endif

    // Registered display outputs derived from the next state; bcd_out holds outside ON.
    always_comb begin
        bcd_d = bcd_q;
        an_d  = '1;
        fs_d  = enter_frame;
        if (state_d == StOn) begin
            bcd_d = nib;
            if (nib != 4'hF && lz_ok) begin
                an_d[idx_d] = 1'b0;
            end
        end
    end

    // All state and outputs, async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            load_ready_q <= 1'b1;
            bcd_q        <= '0;
            an_q         <= '1;
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            load_ready_q <= load_ready_d;
            bcd_q        <= bcd_d;
            an_q         <= an_d;
            fs_q         <= fs_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign bcd_out     = bcd_q;
    assign dig_an_n    = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
// Honours SEG_LZ_BLANK_EN when deciding which anodes should light.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_an_n;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .PRESCALE    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .bcd_out    (bcd_out),
        .dig_an_n   (dig_an_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [3:0] bcd;
        logic       fs;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && !load_ready; i++) step();
        chk("ready_wait", {15'd0, load_ready}, 16'd1);
    endtask

    task automatic wait_fs();
        step();
        for (int i = 0; i < 100 && !frame_start; i++) step();
        chk("fs_wait", {15'd0, frame_start}, 16'd1);
    endtask

    task automatic load_word(input logic [15:0] w);
        wait_ready();
        load_valid = 1'b1;
        load_data  = w;
        step();
        load_valid = 1'b0;
        chk("ready_drop", {15'd0, load_ready}, 16'd0);
    endtask

    function automatic logic [3:0] exp_an(input logic [15:0] w, input int k);
        logic [3:0] nb;
        logic       shown;
`ifdef SEG_LZ_BLANK_EN
        int msd;
        msd = 0;
        for (int j = 0; j < 4; j++) if (w[4*j +: 4] != 4'h0) msd = j;
`endif
        nb    = w[4*k +: 4];
        shown = (nb != 4'hF);
`ifdef SEG_LZ_BLANK_EN
        shown = shown && (k <= msd);
`endif
        exp_an = 4'hF;
        if (shown) exp_an[k] = 1'b0;
    endfunction

    // Called on the first ON cycle of digit 0; checks the first ON cycle of every digit.
    task automatic check_frame(input logic [15:0] w, input string tag);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) for (int s = 0; s < 8; s++) step();
            chk($sformatf("%s_an%0d", tag, k), {12'd0, dig_an_n}, {12'd0, exp_an(w, k)});
            chk($sformatf("%s_bcd%0d", tag, k), {12'd0, bcd_out}, {12'd0, w[4*k +: 4]});
        end
    endtask

    // At most one anode low at any time.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(~dig_an_n) > 1) begin
                errors++;
                $display("FAIL one_hot_anode: got %b expected at most one zero", dig_an_n);
            end
        end
    end

    initial begin
        tbl[0]  = '{n: 1,  an: 4'b1110, bcd: 4'h4, fs: 1'b1};
        tbl[1]  = '{n: 2,  an: 4'b1110, bcd: 4'h4, fs: 1'b0};
        tbl[2]  = '{n: 6,  an: 4'b1110, bcd: 4'h4, fs: 1'b0};
        tbl[3]  = '{n: 7,  an: 4'b1111, bcd: 4'h4, fs: 1'b0};
        tbl[4]  = '{n: 8,  an: 4'b1111, bcd: 4'h4, fs: 1'b0};
        tbl[5]  = '{n: 9,  an: 4'b1101, bcd: 4'h3, fs: 1'b0};
        tbl[6]  = '{n: 16, an: 4'b1111, bcd: 4'h3, fs: 1'b0};
        tbl[7]  = '{n: 17, an: 4'b1011, bcd: 4'h2, fs: 1'b0};
        tbl[8]  = '{n: 25, an: 4'b0111, bcd: 4'h1, fs: 1'b0};
        tbl[9]  = '{n: 30, an: 4'b0111, bcd: 4'h1, fs: 1'b0};
        tbl[10] = '{n: 31, an: 4'b1111, bcd: 4'h1, fs: 1'b0};
        tbl[11] = '{n: 33, an: 4'b1110, bcd: 4'h4, fs: 1'b1};

        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0;
        #12;
        chk("rst_an", {12'd0, dig_an_n}, 16'h000F);
        chk("rst_bcd", {12'd0, bcd_out}, 16'h0000);
        chk("rst_ready", {15'd0, load_ready}, 16'd1);
        chk("rst_fs", {15'd0, frame_start}, 16'd0);
        rst_n = 1'b1;
        step();

        // Load while idle: copy on the following cycle, ready back one cycle later.
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_valid = 1'b0;
        chk("idle_ready_0a", {15'd0, load_ready}, 16'd0);
        step();
        chk("idle_ready_0b", {15'd0, load_ready}, 16'd0);
        step();
        chk("idle_ready_1", {15'd0, load_ready}, 16'd1);

        // First frame timing against the vector table.
        enable = 1'b1;
        cyc    = 0;
        for (int i = 0; i < 12; i++) begin
            run_to(tbl[i].n);
            chk($sformatf("tbl%0d_an", i), {12'd0, dig_an_n}, {12'd0, tbl[i].an});
            chk($sformatf("tbl%0d_bcd", i), {12'd0, bcd_out}, {12'd0, tbl[i].bcd});
            chk($sformatf("tbl%0d_fs", i), {15'd0, frame_start}, {15'd0, tbl[i].fs});
        end

        // Load during digit 2 ON with valid held; second value waits for ready.
        run_to(49);
        load_valid = 1'b1;
        load_data  = 16'h5678;
        run_to(50);
        chk("mid_ready_0", {15'd0, load_ready}, 16'd0);
        load_data = 16'h9ABC;
        run_to(57);
        chk("old_bcd_d3", {12'd0, bcd_out}, 16'h0001);
        chk("old_an_d3", {12'd0, dig_an_n}, 16'h0007);
        run_to(65);
        chk("f3_fs", {15'd0, frame_start}, 16'd1);
        chk("f3_bcd0", {12'd0, bcd_out}, 16'h0008);
        chk("f3_ready_0", {15'd0, load_ready}, 16'd0);
        run_to(66);
        chk("f3_ready_1", {15'd0, load_ready}, 16'd1);
        chk("f3_bcd0b", {12'd0, bcd_out}, 16'h0008);
        run_to(67);
        chk("second_taken", {15'd0, load_ready}, 16'd0);
        load_valid = 1'b0;
        run_to(73);
        chk("f3_bcd1", {12'd0, bcd_out}, 16'h0007);
        run_to(89);
        chk("f3_bcd3", {12'd0, bcd_out}, 16'h0005);
        run_to(97);
        chk("f4_fs", {15'd0, frame_start}, 16'd1);
        chk("f4_bcd0", {12'd0, bcd_out}, 16'h000C);
        run_to(105);
        chk("f4_bcd1", {12'd0, bcd_out}, 16'h000B);
        run_to(121);
        chk("f4_bcd3", {12'd0, bcd_out}, 16'h0009);

        // Blank code digits.
        load_word(16'hF0F5);
        wait_fs();
        check_frame(16'hF0F5, "f0f5");

        // Disable during BLANK of digit 2, then re-enable.
        wait_fs();
        for (int s = 0; s < 22; s++) step();
        chk("d2_blank_an", {12'd0, dig_an_n}, 16'h000F);
        enable = 1'b0;
        step();
        chk("dis_an", {12'd0, dig_an_n}, 16'h000F);
        chk("dis_fs", {15'd0, frame_start}, 16'd0);
        step();
        step();
        chk("dis_an_hold", {12'd0, dig_an_n}, 16'h000F);
        enable = 1'b1;
        step();
        chk("reen_fs", {15'd0, frame_start}, 16'd1);
        chk("reen_an", {12'd0, dig_an_n}, 16'h000E);
        chk("reen_bcd", {12'd0, bcd_out}, 16'h0005);
        step();
        chk("reen_fs_pulse", {15'd0, frame_start}, 16'd0);
        chk("reen_an_b", {12'd0, dig_an_n}, 16'h000E);

        // Asynchronous reset mid-ON.
        #1 rst_n = 1'b0;
        #1;
        chk("arst_an", {12'd0, dig_an_n}, 16'h000F);
        chk("arst_bcd", {12'd0, bcd_out}, 16'h0000);
        chk("arst_ready", {15'd0, load_ready}, 16'd1);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_fs", {15'd0, frame_start}, 16'd1);
        chk("post_rst_an", {12'd0, dig_an_n}, 16'h000E);
        chk("post_rst_bcd", {12'd0, bcd_out}, 16'h0000);

        // Leading-zero cases (all digits lit when suppression is not built in).
        load_word(16'h0042);
        wait_fs();
        check_frame(16'h0042, "w0042");
        load_word(16'h0000);
        wait_fs();
        check_frame(16'h0000, "w0000");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
